refill_beat_packer: RTL and testbench
=====================================

// Module: refill_beat_packer
// PURPOSE
//  Upstream feeder of the L1.5 replay buffer: packs narrow refill beats from the L2/AXI read channel
//  into OUT_WIDTH-bit words and presents them on a VALID/GRANT push interface.
//  First beat fills the least-significant lane. Early 'last' flushes a zero-padded partial word.
//  One-word output register; back-to-back pop+fill sustains one beat per cycle.
// PARAMETERS
//  IN_WIDTH   32  width of one refill beat
//  OUT_WIDTH  64  packed word width; integer multiple of IN_WIDTH; R = OUT_WIDTH/IN_WIDTH, R in 1..16
// PORTS
//  clk            in   1          clock, all logic on rising edge
//  rst            in   1          synchronous reset, active-high
//  beat_data_i    in   IN_WIDTH   refill beat payload
//  beat_last_i    in   1          final beat of the refill burst
//  beat_valid_i   in   1          beat present
//  beat_grant_o   out  1          beat accepted this cycle when beat_valid_i & beat_grant_o
//  word_data_o    out  OUT_WIDTH  packed word to replay buffer
//  word_valid_o   out  1          word present
//  word_grant_i   in   1          word consumed when word_valid_o & word_grant_i
//  word_last_o    out  1          word contains the burst's final beat
//  word_partial_o out  1          word closed by last before R beats; upper lanes zero
// BEHAVIOUR
//  Reset (rst=1 at edge, dominates all): state FILL, lane count cnt=0, word_data_o=0, word_valid_o=0,
//   word_last_o=0, word_partial_o=0. beat_grant_o=1 from the first cycle after reset release.
//  Mid-operation reset drops any partially filled or held word. No word is emitted.
//  States: FILL (accumulating, word_valid_o=0) and HOLD (word complete, word_valid_o=1).
//  FILL: beat_grant_o=1. On accepted beat: lane[cnt] <= beat_data_i.
//   If cnt==R-1 or beat_last_i: go to HOLD. Set word_last_o=beat_last_i.
//   Set word_partial_o = beat_last_i & (cnt!=R-1). Lanes above cnt are zero. cnt <= 0.
//   Otherwise cnt <= cnt+1.
//  FILL with beat_valid_i=0: everything holds.
//  HOLD: beat_grant_o = word_grant_i (combinational). word_data_o/last/partial stable until popped.
//   Pop without accepted beat: all lanes <= 0, flags <= 0, go to FILL.
//   Pop with accepted beat: this cycle's beat is written as lane 0 of a fresh word
//    (other lanes 0), with the FILL rules applied at cnt=0.
//    R==1, or beat_last_i=1: stay HOLD with the new word. Otherwise go to FILL with cnt=1.
//   No pop: beat_grant_o=0, nothing changes.
//  Latency: the last beat of a word is accepted in cycle N; word_valid_o=1 in cycle N+1.
//   Throughput: one beat per cycle. No bubble at word boundaries when word_grant_i is held high.
//  Lane writes always clear the unused lanes, so zero padding never depends on the previous word.
//  word_data_o is driven straight from the register; no combinational path from beat_data_i.
//   beat_grant_o is the only combinational output; in HOLD it depends only on word_grant_i.
//  cnt is $clog2(R) bits wide, minimum 1. It never exceeds R-1 and never wraps.
//  beat_last_i is ignored unless its beat is accepted.
// TESTING
//  1 Reset: hold rst 3 cycles, then release.
//    -> word_valid_o=0 and word_data_o=0 throughout; beat_grant_o=1 on the first cycle after release.
//  2 R=2, grant_i=1: beats 0x11111111, 0x22222222(last), one per cycle.
//    -> one cycle later word 0x22222222_11111111 with last=1, partial=0; grant_o=1 every cycle.
//  3 R=2: beats 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC(last) back-to-back, grant_i=1.
//    -> words 0xBBBBBBBB_AAAAAAAA (last=0), then 0x00000000_CCCCCCCC (last=1, partial=1).
//  4 Backpressure: word held while grant_i=0 for 5 cycles with beat_valid_i=1.
//    -> grant_o=0 and word_data_o stable for all 5 cycles. When grant_i rises, the pending beat
//       goes into lane 0 the same cycle.
//  5 IN_WIDTH=OUT_WIDTH=64 (R=1), continuous beats, grant_i=1.
//    -> each beat appears one cycle later; word_valid_o stays 1; never partial.
//  6 Assert rst while a word is held and half of the next is filled.
//    -> next cycle valid=0, data=0, cnt=0. After release, a new 2-beat burst packs from lane 0.

Source files
------------

// File: rtl/refill_beat_packer_if.sv
// Refill packer bus bundle.
//   beat_*  : narrow refill beats from the L2/AXI read channel (valid/grant)
//   word_*  : packed OUT_WIDTH-bit words to the replay buffer (valid/grant)
// Modports:
//   master : environment side, drives beats and word_grant_i
//   slave  : packer side, drives beat_grant_o and the word outputs
interface refill_beat_packer_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 64
) ();
  logic [IN_WIDTH-1:0]  beat_data_i;
  logic                 beat_last_i;
  logic                 beat_valid_i;
  logic                 beat_grant_o;
  logic [OUT_WIDTH-1:0] word_data_o;
  logic                 word_valid_o;
  logic                 word_grant_i;
  logic                 word_last_o;
  logic                 word_partial_o;

  modport master (
    output beat_data_i, beat_last_i, beat_valid_i, word_grant_i,
    input  beat_grant_o, word_data_o, word_valid_o, word_last_o, word_partial_o
  );

  modport slave (
    input  beat_data_i, beat_last_i, beat_valid_i, word_grant_i,
    output beat_grant_o, word_data_o, word_valid_o, word_last_o, word_partial_o
  );
endinterface

// File: rtl/refill_beat_packer.sv
// Packs IN_WIDTH-bit refill beats into OUT_WIDTH-bit words, first beat in the
// least-significant lane. An early 'last' closes a zero-padded partial word.
// Single word register; pop and refill in the same cycle keeps one beat/cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : refill_beat_packer_if.slave (beat input channel, word output channel)
module refill_beat_packer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  refill_beat_packer_if.slave  bus
);
  localparam int unsigned R  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic                 partial_q, partial_d;

  logic                 wr_en;
  logic [CW-1:0]        wr_idx;
  logic                 wr_closes;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    last_d           = last_q;
    partial_d        = partial_q;
    wr_en            = 1'b0;
    wr_idx           = cnt_q;
    wr_closes        = 1'b0;
    bus.beat_grant_o = 1'b1;

    unique case (state_q)
      StFill: begin
        bus.beat_grant_o = 1'b1;
        wr_en            = bus.beat_valid_i;
      end
      StHold: begin
        bus.beat_grant_o = bus.word_grant_i;
        if (bus.word_grant_i) begin
          // Pop: clear the whole word so a refill in this same cycle starts
          // from an all-zero word and padding never leaks old data.
          data_d    = '0;
          last_d    = 1'b0;
          partial_d = 1'b0;
          state_d   = StFill;
          cnt_d     = '0;
          wr_en     = bus.beat_valid_i;
          wr_idx    = '0;
        end
      end
      default: ;
    endcase

    if (wr_en) begin
      // Lanes above wr_idx are already zero: every word starts cleared.
      for (int l = 0; l < int'(R); l++) begin
        if (wr_idx == CW'(l)) begin
          data_d[l*IN_WIDTH +: IN_WIDTH] = bus.beat_data_i;
        end
      end
      wr_closes = (wr_idx == CW'(R - 1)) || bus.beat_last_i;
      if (wr_closes) begin
        state_d   = StHold;
        last_d    = bus.beat_last_i;
        partial_d = bus.beat_last_i && (wr_idx != CW'(R - 1));
        cnt_d     = '0;
      end else begin
        state_d   = StFill;
        cnt_d     = wr_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      partial_q <= partial_d;
    end
  end

  assign bus.word_data_o    = data_q;
  assign bus.word_valid_o   = (state_q == StHold);
  assign bus.word_last_o    = last_q;
  assign bus.word_partial_o = partial_q;
endmodule

// File: tb/tb_refill_beat_packer.sv
// Bench for refill_beat_packer: two instances (R=2 with 32->64, R=1 with 64->64),
// a queue-based reference model per instance checked every cycle, directed
// literal checks, then randomized traffic with occasional resets.
module tb_refill_beat_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Channel-indexed stimulus/observation; channel 0 is R=2, channel 1 is R=1.
  logic [63:0] bd [2];
  logic [63:0] wd [2];
  logic [1:0]  bv, bl, wg, bg, wv, wlast, wpart;

  refill_beat_packer_if #(.IN_WIDTH(32), .OUT_WIDTH(64)) bus0 ();
  refill_beat_packer_if #(.IN_WIDTH(64), .OUT_WIDTH(64)) bus1 ();

  refill_beat_packer #(.IN_WIDTH(32), .OUT_WIDTH(64)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  refill_beat_packer #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.beat_data_i  = bd[0][31:0];
  assign bus0.beat_last_i  = bl[0];
  assign bus0.beat_valid_i = bv[0];
  assign bus0.word_grant_i = wg[0];
  assign bg[0]    = bus0.beat_grant_o;
  assign wd[0]    = bus0.word_data_o;
  assign wv[0]    = bus0.word_valid_o;
  assign wlast[0] = bus0.word_last_o;
  assign wpart[0] = bus0.word_partial_o;

  assign bus1.beat_data_i  = bd[1];
  assign bus1.beat_last_i  = bl[1];
  assign bus1.beat_valid_i = bv[1];
  assign bus1.word_grant_i = wg[1];
  assign bg[1]    = bus1.beat_grant_o;
  assign wd[1]    = bus1.word_data_o;
  assign wv[1]    = bus1.word_valid_o;
  assign wlast[1] = bus1.word_last_o;
  assign wpart[1] = bus1.word_partial_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: collect accepted beats; a word exists once R beats or a
  // last beat have been collected, and leaves when the consumer grants it.
  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        p;
  } word_t;

  for (genvar c = 0; c < 2; c++) begin : g_model
    localparam int RR  = (c == 0) ? 2 : 1;
    localparam int INW = 64 / RR;

    logic [63:0] cur[$];
    word_t       expq[$];
    logic        s_rst  = 1'b1;
    logic        s_take = 1'b0;
    logic        s_pop  = 1'b0;
    logic        s_last = 1'b0;
    logic [63:0] s_data = '0;

    always @(negedge clk) begin
      chk($sformatf("ch%0d word_valid", c), 64'(wv[c]), 64'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk($sformatf("ch%0d word_data", c), wd[c], expq[0].d);
        chk($sformatf("ch%0d word_last", c), 64'(wlast[c]), 64'(expq[0].l));
        chk($sformatf("ch%0d word_partial", c), 64'(wpart[c]), 64'(expq[0].p));
      end
      if (!rst) begin
        // A beat is taken unless a finished word is stuck waiting for the consumer.
        chk($sformatf("ch%0d beat_grant", c), 64'(bg[c]),
            64'((expq.size() == 0) || wg[c]));
      end
      s_rst  = rst;
      s_pop  = (expq.size() != 0) && wg[c];
      s_take = bv[c] && ((expq.size() == 0) || wg[c]);
      s_last = bl[c];
      s_data = (c == 0) ? {32'h0, bd[c][31:0]} : bd[c];
    end

    always @(posedge clk) begin
      if (s_rst) begin
        cur.delete();
        expq.delete();
      end else begin
        if (s_pop) void'(expq.pop_front());
        if (s_take) begin
          cur.push_back(s_data);
          if (cur.size() == RR || s_last) begin
            word_t w;
            w.d = '0;
            for (int i = 0; i < cur.size(); i++) w.d = w.d | (cur[i] << (i * INW));
            w.l = s_last;
            w.p = s_last && (cur.size() < RR);
            expq.push_back(w);
            cur.delete();
          end
        end
      end
    end
  end

  localparam logic [31:0] D0 = 32'hD0D0_0000, D1 = 32'hD1D1_1111, D2 = 32'hD2D2_2222;
  localparam logic [31:0] D3 = 32'hD3D3_3333, D4 = 32'hD4D4_4444, D5 = 32'hD5D5_5555;
  localparam logic [31:0] D6 = 32'hD6D6_6666, E0 = 32'hE0E0_0E0E, E1 = 32'hE1E1_1E1E;

  initial begin
    bv = '0; bl = '0; wg = 2'b11;
    bd[0] = '0; bd[1] = '0;

    // 1: reset held three cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst valid0", 64'(wv[0]), 64'd0);
      chk("rst data0", wd[0], 64'd0);
      chk("rst valid1", 64'(wv[1]), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("grant after release", 64'(bg[0]), 64'd1);

    // 2: two-beat full word
    bv[0] = 1'b1; bd[0] = 64'h1111_1111; bl[0] = 1'b0;
    #1 chk("t2 grant a", 64'(bg[0]), 64'd1);
    tick();
    bd[0] = 64'h2222_2222; bl[0] = 1'b1;
    #1 chk("t2 grant b", 64'(bg[0]), 64'd1);
    tick();
    bv[0] = 1'b0; bl[0] = 1'b0;
    chk("t2 valid", 64'(wv[0]), 64'd1);
    chk("t2 data", wd[0], 64'h2222_2222_1111_1111);
    chk("t2 last", 64'(wlast[0]), 64'd1);
    chk("t2 partial", 64'(wpart[0]), 64'd0);
    tick();

    // 3: full word then a partial one, back-to-back
    bv[0] = 1'b1; bd[0] = 64'hAAAA_AAAA;
    tick();
    bd[0] = 64'hBBBB_BBBB;
    tick();
    chk("t3 w1 data", wd[0], 64'hBBBB_BBBB_AAAA_AAAA);
    chk("t3 w1 last", 64'(wlast[0]), 64'd0);
    bd[0] = 64'hCCCC_CCCC; bl[0] = 1'b1;
    #1 chk("t3 no bubble", 64'(bg[0]), 64'd1);
    tick();
    bv[0] = 1'b0; bl[0] = 1'b0;
    chk("t3 w2 valid", 64'(wv[0]), 64'd1);
    chk("t3 w2 data", wd[0], 64'h0000_0000_CCCC_CCCC);
    chk("t3 w2 last", 64'(wlast[0]), 64'd1);
    chk("t3 w2 partial", 64'(wpart[0]), 64'd1);
    tick();

    // 4: backpressure for five cycles with a beat pending
    wg[0] = 1'b0; bv[0] = 1'b1; bd[0] = 64'(D0);
    tick();
    bd[0] = 64'(D1);
    tick();
    bd[0] = 64'(D2);
    for (int i = 0; i < 5; i++) begin
      chk("t4 grant low", 64'(bg[0]), 64'd0);
      chk("t4 data stable", wd[0], {D1, D0});
      tick();
    end
    wg[0] = 1'b1;
    #1 chk("t4 grant follows", 64'(bg[0]), 64'd1);
    tick();
    chk("t4 popped", 64'(wv[0]), 64'd0);
    chk("t4 lane0", wd[0], {32'h0, D2});
    bd[0] = 64'(D3); bl[0] = 1'b1;
    tick();
    bv[0] = 1'b0; bl[0] = 1'b0;
    chk("t4 data", wd[0], {D3, D2});
    chk("t4 partial", 64'(wpart[0]), 64'd0);
    tick();

    // 6: reset with a half-filled word, then reset with a held word
    wg[0] = 1'b0; bv[0] = 1'b1; bd[0] = 64'(D4);
    tick();
    bd[0] = 64'(D5);
    tick();
    wg[0] = 1'b1; bd[0] = 64'(D6);
    tick();
    rst = 1'b1; bv[0] = 1'b0;
    tick();
    chk("t6 rst valid", 64'(wv[0]), 64'd0);
    chk("t6 rst data", wd[0], 64'd0);
    rst = 1'b0; wg[0] = 1'b0; bv[0] = 1'b1; bd[0] = 64'(D4);
    tick();
    bd[0] = 64'(D5);
    tick();
    rst = 1'b1; bv[0] = 1'b0;
    tick();
    chk("t6 rst held valid", 64'(wv[0]), 64'd0);
    chk("t6 rst held data", wd[0], 64'd0);
    rst = 1'b0; wg[0] = 1'b1; bv[0] = 1'b1; bd[0] = 64'(E0);
    tick();
    bd[0] = 64'(E1); bl[0] = 1'b1;
    tick();
    bv[0] = 1'b0; bl[0] = 1'b0;
    chk("t6 new burst", wd[0], {E1, E0});
    chk("t6 new last", 64'(wlast[0]), 64'd1);
    tick();

    // 5: R=1, continuous beats
    wg[1] = 1'b1; bv[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bd[1] = 64'h5A5A_0000_0000_0000 + 64'(i);
      bl[1] = (i == 3);
      tick();
      chk("t5 valid", 64'(wv[1]), 64'd1);
      chk("t5 data", wd[1], 64'h5A5A_0000_0000_0000 + 64'(i));
      chk("t5 partial", 64'(wpart[1]), 64'd0);
      chk("t5 last", 64'(wlast[1]), 64'(i == 3));
    end
    bv[1] = 1'b0; bl[1] = 1'b0;
    tick();

    // Random traffic on both channels, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < 2; c++) begin
        bv[c] = ($urandom_range(0, 3) != 0);
        bl[c] = ($urandom_range(0, 4) == 0);
        bd[c] = {$urandom, $urandom};
        wg[c] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rst = 1'b0; bv = '0; bl = '0; wg = 2'b11;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
